// File: rtl/gate_bank_sequencer.sv
// rtl/gate_bank_sequencer.sv - self-test sequencer for the built-in gate bank
// Walks input vectors through the bank, checks o1..o10 against a golden model.
module gate_bank_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_VECTORS   = 16,
    parameter int CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [9:0]       gate_o,
    output logic             gate_a,
    output logic             gate_b,
    output logic             gate_c,
    output logic             gate_d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       first_fail_vec,
    output logic [9:0]       first_fail_obs
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0]       LAST_IDX = 4'(NUM_VECTORS - 1);
    localparam logic [7:0]       RELOAD   = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_idx;
    logic [7:0]       r_cnt;
    logic [3:0]       r_drive;
    logic             r_pass;
    logic [CNT_W-1:0] r_err;
    logic [3:0]       r_ffv;
    logic [9:0]       r_ffo;
    logic [9:0]       w_golden;
    logic             w_mismatch;

    function automatic logic [9:0] golden(input logic [3:0] v);
        logic a, b, c, d;
        logic [9:0] o;
        {a, b, c, d} = v;
        o[0] = a & b;
        o[1] = ~(a & b);
        o[2] = a | b | c | d;
        o[3] = ~(c | d);
        o[4] = a ^ b ^ c ^ d;
        o[5] = ~(b ^ d);
        o[6] = c;
        o[7] = ~d;
        o[8] = c;
        o[9] = a & b;
        return o;
    endfunction

    assign w_golden   = golden(r_idx);
    assign w_mismatch = (gate_o != w_golden);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start && !abort) w_next = S_SETTLE;
            S_SETTLE: begin
                if (abort)            w_next = S_IDLE;
                else if (r_cnt == '0) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)                 w_next = S_IDLE;
                else if (r_idx == LAST_IDX) w_next = S_DONE;
                else                       w_next = S_SETTLE;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_drive <= '0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ffv   <= '0;
            r_ffo   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_idx   <= '0;
                        r_drive <= '0;
                        r_cnt   <= RELOAD;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
                        r_ffv   <= '0;
                        r_ffo   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort)            r_drive <= '0;
                    else if (r_cnt != '0) r_cnt   <= r_cnt - 8'd1;
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_drive <= '0;
                    end else begin
                        // A zero count means no earlier mismatch, since the count saturates.
                        if (w_mismatch) begin
                            if (r_err != '1) r_err <= r_err + ERR_ONE;
                            if (r_err == '0) begin
                                r_ffv <= r_idx;
                                r_ffo <= gate_o;
                            end
                        end
                        if (r_idx == LAST_IDX) begin
                            r_drive <= '0;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_drive <= r_idx + 4'd1;
                            r_cnt   <= RELOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_drive <= '0;
                    r_pass  <= !abort && (r_err == '0);
                end
                default: r_drive <= '0;
            endcase
        end
    end

    assign {gate_a, gate_b, gate_c, gate_d} = r_drive;
    assign busy           = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done           = (r_state == S_DONE);
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail_vec = r_ffv;
    assign first_fail_obs = r_ffo;

endmodule

// File: tb/tb_gate_bank_sequencer.sv
// tb/tb_gate_bank_sequencer.sv - scoreboard bench for gate_bank_sequencer
// Three instances: defaults, NUM_VECTORS=4, SETTLE_CYCLES=1; each drives its own bank model.
module tb_gate_bank_sequencer;

    typedef struct {
        int dut;
        int cyc;
        int err;
        int ffv;
        int ffo;
        int pas;
    } exp_t;

    logic       clk;
    logic       rstn   [3];
    logic       start  [3];
    logic       abort  [3];
    logic [9:0] gate_o [3];
    logic       ga [3], gb [3], gc [3], gd [3];
    logic       busy [3], done [3], pass [3];
    logic [4:0] errc [3];
    logic [3:0] ffv  [3];
    logic [9:0] ffo  [3];
    int         fault [3];
    int         t0    [3];
    int         done_cnt [3];
    logic       pend_pass [3];
    int         exp_pass  [3];
    int         sv_cyc [3];
    int         nv_cfg [3];
    int         edge_cnt;
    logic       mon_en;
    int         n_checks;
    int         n_errors;
    exp_t       sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [9:0] bank(input int f, input logic [3:0] v);
        logic a, b, c, d;
        logic [9:0] o;
        {a, b, c, d} = v;
        o[0] = a & b;      o[1] = ~(a & b);   o[2] = a | b | c | d;
        o[3] = ~(c | d);   o[4] = a ^ b ^ c ^ d;
        o[5] = ~(b ^ d);   o[6] = c;          o[7] = ~d;
        o[8] = c;          o[9] = a & b;
        if (f == 1) o[4] = 1'b0;
        if (f == 2) o[9] = ~(a & b);
        return o;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_bank
        assign gate_o[g] = bank(fault[g], {ga[g], gb[g], gc[g], gd[g]});
    end

    gate_bank_sequencer u_dut (
        .clk(clk), .rst_n(rstn[0]), .start(start[0]), .abort(abort[0]), .gate_o(gate_o[0]),
        .gate_a(ga[0]), .gate_b(gb[0]), .gate_c(gc[0]), .gate_d(gd[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
        .first_fail_vec(ffv[0]), .first_fail_obs(ffo[0])
    );

    gate_bank_sequencer #(.NUM_VECTORS(4)) u_dut_n4 (
        .clk(clk), .rst_n(rstn[1]), .start(start[1]), .abort(abort[1]), .gate_o(gate_o[1]),
        .gate_a(ga[1]), .gate_b(gb[1]), .gate_c(gc[1]), .gate_d(gd[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
        .first_fail_vec(ffv[1]), .first_fail_obs(ffo[1])
    );

    gate_bank_sequencer #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rstn[2]), .start(start[2]), .abort(abort[2]), .gate_o(gate_o[2]),
        .gate_a(ga[2]), .gate_b(gb[2]), .gate_c(gc[2]), .gate_d(gd[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
        .first_fail_vec(ffv[2]), .first_fail_obs(ffo[2])
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and tracks the vector walk.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (pend_pass[k]) begin
                    check("pass", int'(pass[k]), exp_pass[k]);
                    pend_pass[k] = 1'b0;
                end
                if (done[k] === 1'b1) begin
                    done_cnt[k]++;
                    if (sb.size() == 0 || sb[0].dut != k) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_done: dut %0d pulsed done with no run expected", k);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("done_cycle", edge_cnt - t0[k] + 1, e.cyc);
                        check("err_count", int'(errc[k]), e.err);
                        check("first_fail_vec", int'(ffv[k]), e.ffv);
                        check("first_fail_obs", int'(ffo[k]), e.ffo);
                        exp_pass[k]  = e.pas;
                        pend_pass[k] = 1'b1;
                    end
                end
                if (busy[k] === 1'b1)
                    check("drive_vector", int'({ga[k], gb[k], gc[k], gd[k]}),
                          ((edge_cnt - t0[k]) / (sv_cyc[k] + 1)) % 16);
                else if (done[k] !== 1'b1)
                    check("drive_idle", int'({ga[k], gb[k], gc[k], gd[k]}), 0);
            end
        end
    end

    task automatic run_start(input int k, input bit push, input int e_err, input int e_ffv,
                             input int e_ffo, input int e_pass);
        exp_t e;
        @(negedge clk);
        start[k] = 1'b1;
        t0[k] = edge_cnt + 1;
        if (push) begin
            e = '{k, nv_cfg[k] * (sv_cyc[k] + 1) + 1, e_err, e_ffv, e_ffo, e_pass};
            sb.push_back(e);
        end
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int c0;
        int n;
        c0 = done_cnt[k];
        n = 0;
        while (done_cnt[k] == c0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done_cnt[k] != c0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_cleared(input int k);
        check("rst_busy", int'(busy[k]), 0);
        check("rst_done", int'(done[k]), 0);
        check("rst_pass", int'(pass[k]), 0);
        check("rst_err", int'(errc[k]), 0);
        check("rst_ffv", int'(ffv[k]), 0);
        check("rst_ffo", int'(ffo[k]), 0);
        check("rst_drive", int'({ga[k], gb[k], gc[k], gd[k]}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        edge_cnt = 0;
        mon_en   = 1'b0;
        sv_cyc   = '{4, 4, 1};
        nv_cfg   = '{16, 4, 16};
        for (int k = 0; k < 3; k++) begin
            rstn[k] = 1'b0; start[k] = 1'b0; abort[k] = 1'b0; fault[k] = 0;
            t0[k] = 0; done_cnt[k] = 0; pend_pass[k] = 1'b0; exp_pass[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_cleared(k);
        for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
        mon_en = 1'b1;

        // Fault-free bank, full run.
        run_start(0, 1, 0, 0, 0, 1);
        wait_done(0);

        // o5 stuck at 0: odd-parity vectors fail; first is vector 1, observed 0x006.
        fault[0] = 1;
        run_start(0, 1, 8, 1, 'h006, 0);
        wait_done(0);

        // o10 inverted, four vectors: every vector fails, first observation 0x2AA.
        fault[1] = 2;
        run_start(1, 1, 4, 0, 'h2AA, 0);
        wait_done(1);

        // Abort in the third settle cycle of vector 5; vectors 1, 2, 4 already failed.
        fault[0] = 1;
        run_start(0, 0, 0, 0, 0, 0);
        while (edge_cnt < t0[0] + 27) @(negedge clk);
        check("busy_before_abort", int'(busy[0]), 1);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("abort_busy", int'(busy[0]), 0);
        check("abort_drive", int'({ga[0], gb[0], gc[0], gd[0]}), 0);
        check("abort_pass", int'(pass[0]), 0);
        check("abort_err", int'(errc[0]), 3);
        check("abort_ffv", int'(ffv[0]), 1);
        check("abort_ffo", int'(ffo[0]), 'h006);
        repeat (6) @(negedge clk);
        check("abort_still_idle", int'(busy[0]), 0);

        // Start re-pulsed mid-run is ignored; then start+abort in IDLE does nothing.
        fault[0] = 0;
        run_start(0, 1, 0, 0, 0, 1);
        repeat (10) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("start_abort_busy", int'(busy[0]), 0);
        repeat (5) @(negedge clk);
        check("start_abort_idle", int'(busy[0]), 0);
        check("start_abort_pass", int'(pass[0]), 1);

        // Reset mid-run on the SETTLE_CYCLES=1 instance, then a clean run.
        fault[2] = 1;
        run_start(2, 0, 0, 0, 0, 0);
        repeat (7) @(negedge clk);
        check("pre_reset_err", int'(errc[2]), 2);
        rstn[2] = 1'b0;
        @(negedge clk);
        rstn[2] = 1'b1;
        check_cleared(2);
        fault[2] = 0;
        run_start(2, 1, 0, 0, 0, 1);
        wait_done(2);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
